// File: rtl/pmod_jstk_reader_pkg.sv
// Shared definitions for the PmodJSTK reader: FSM state encoding, direction
// encoding, frame layout constants and the axis threshold classifier.
package pmod_jstk_reader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    GAP,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    DIR_NONE,
    DIR_NEG,   // left on X, down on Y
    DIR_POS    // right on X, up on Y
  } dir_t;

  // One joystick frame is five bytes: X low, X high, Y low, Y high, buttons.
  localparam int NUM_BYTES          = 5;
  localparam int BTN_BYTE           = 4;
  localparam int BTN_DOWN_CLICK_BIT = 0;
  localparam int BTN_CLICK_BIT      = 1;

  localparam int NUM_AXES = 2;
  localparam int AXIS_X   = 0;
  localparam int AXIS_Y   = 1;

  localparam logic [9:0] AXIS_CENTER = 10'd512;

  // Threshold values themselves count as active.
  function automatic dir_t classify_axis(input logic [9:0] value,
                                         input logic [9:0] low_th,
                                         input logic [9:0] high_th);
    if (value <= low_th) return DIR_NEG;
    if (value >= high_th) return DIR_POS;
    return DIR_NONE;
  endfunction

endpackage

// File: rtl/pmod_jstk_reader_if.sv
// SPI pin bundle between the reader (master) and the PmodJSTK (slave).
//   SS   : slave select, active low (master -> slave)
//   MOSI : data to joystick, held at 0 (master -> slave)
//   SCLK : SPI mode-0 clock (master -> slave)
//   MISO : data from joystick (slave -> master)
interface pmod_jstk_reader_if;
  logic SS;
  logic MOSI;
  logic SCLK;
  logic MISO;

  modport master (output SS, output MOSI, output SCLK, input MISO);
  modport slave  (input SS, input MOSI, input SCLK, output MISO);
endinterface

// File: rtl/pmod_jstk_reader_spi_byte_shifter.sv
// Mode-0 SPI byte receiver: generates SCLK for 8 bits and shifts MISO in
// MSB first.
//   clk, rst : system clock, synchronous active-high reset
//   start    : one-cycle request to clock a byte (ignored while busy)
//   miso     : serial data in, sampled on the clk where SCLK rises
//   sclk     : SPI clock out, idles low
//   done     : one-cycle pulse after the 8th falling edge
//   rx_byte  : received byte, valid while done is high
module pmod_jstk_reader_spi_byte_shifter #(
  parameter int SCLK_HALF = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       miso,
  output logic       sclk,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int                HALF_W    = $clog2(SCLK_HALF) + 1;
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(SCLK_HALF - 1);

  logic              busy_reg;
  logic [HALF_W-1:0] half_cnt_reg;
  logic [2:0]        bit_cnt_reg;
  logic              sclk_reg;
  logic              done_reg;
  logic [7:0]        shift_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg     <= 1'b0;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      sclk_reg     <= 1'b0;
      done_reg     <= 1'b0;
      shift_reg    <= '0;
    end else begin
      done_reg <= 1'b0;
      if (!busy_reg) begin
        if (start) begin
          busy_reg     <= 1'b1;
          half_cnt_reg <= '0;
          bit_cnt_reg  <= '0;
        end
      end else if (half_cnt_reg == HALF_LAST) begin
        half_cnt_reg <= '0;
        if (!sclk_reg) begin
          // Rising edge: the slave has held this bit stable for a full half period.
          sclk_reg  <= 1'b1;
          shift_reg <= {shift_reg[6:0], miso};
        end else begin
          sclk_reg <= 1'b0;
          if (bit_cnt_reg == 3'd7) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
          end
        end
      end else begin
        half_cnt_reg <= half_cnt_reg + HALF_W'(1);
      end
    end
  end

  assign sclk    = sclk_reg;
  assign done    = done_reg;
  assign rx_byte = shift_reg;

endmodule

// File: rtl/pmod_jstk_reader.sv
// Polls one PmodJSTK over SPI and converts each 5-byte reading into cursor
// step pulses (with auto-repeat) plus raw button levels.
//   clk, rst           : system clock, synchronous active-high reset
//   spi                : SPI master pins (SS, MOSI, SCLK, MISO)
//   left/right         : one-clk X step pulses
//   up/down            : one-clk Y step pulses
//   click, down_click  : raw button levels from the last complete frame
//   x_pos, y_pos       : last complete 10-bit axis samples
//   sample_valid       : one-clk pulse when the outputs above update
module pmod_jstk_reader
  import pmod_jstk_reader_pkg::*;
#(
  parameter int         SCLK_HALF    = 50,
  parameter int         SS_SETUP     = 1500,
  parameter int         BYTE_GAP     = 1000,
  parameter int         POLL_PERIOD  = 1_000_000,
  parameter logic [9:0] LOW_TH       = 10'd256,
  parameter logic [9:0] HIGH_TH      = 10'd768,
  parameter int         REPEAT_POLLS = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  pmod_jstk_reader_if.master       spi,
  output logic                     left,
  output logic                     right,
  output logic                     up,
  output logic                     down,
  output logic                     click,
  output logic                     down_click,
  output logic [9:0]               x_pos,
  output logic [9:0]               y_pos,
  output logic                     sample_valid
);

  localparam int WAIT_MAX = (SS_SETUP > BYTE_GAP) ? SS_SETUP : BYTE_GAP;
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;
  localparam int POLL_W   = $clog2(POLL_PERIOD) + 1;
  localparam int REP_W    = $clog2(REPEAT_POLLS) + 1;

  localparam logic [WAIT_W-1:0] SETUP_LAST = WAIT_W'(SS_SETUP - 1);
  localparam logic [WAIT_W-1:0] GAP_LAST   = WAIT_W'(BYTE_GAP - 1);
  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);
  localparam logic [REP_W-1:0]  REP_LAST   = REP_W'(REPEAT_POLLS - 1);
  localparam logic [2:0]        LAST_BYTE  = 3'(NUM_BYTES - 1);

  state_t            state_reg, state_next;
  logic              shift_start;
  logic              shift_done;
  logic [7:0]        shift_rx;
  logic              ss_reg;
  logic [POLL_W-1:0] poll_cnt_reg;
  logic [WAIT_W-1:0] wait_cnt_reg;
  logic [2:0]        byte_idx_reg;
  logic [7:0]        byte_reg [NUM_BYTES];

  logic [9:0]        x_pos_reg, y_pos_reg;
  logic              click_reg, down_click_reg, sample_valid_reg;
  logic [9:0]        axis_sample [NUM_AXES];
  logic [NUM_AXES-1:0] axis_neg, axis_pos;
  logic              unused_high_bits;

  pmod_jstk_reader_spi_byte_shifter #(
    .SCLK_HALF (SCLK_HALF)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .start   (shift_start),
    .miso    (spi.MISO),
    .sclk    (spi.SCLK),
    .done    (shift_done),
    .rx_byte (shift_rx)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // start is raised on every entry into SHIFT, so each byte gets one request.
  always_comb begin
    state_next  = state_reg;
    shift_start = 1'b0;
    case (state_reg)
      IDLE:  if (poll_cnt_reg == POLL_LAST) state_next = SETUP;
      SETUP: if (wait_cnt_reg == SETUP_LAST) begin
               state_next  = SHIFT;
               shift_start = 1'b1;
             end
      SHIFT: if (shift_done) state_next = (byte_idx_reg == LAST_BYTE) ? DONE : GAP;
      GAP:   if (wait_cnt_reg == GAP_LAST) begin
               state_next  = SHIFT;
               shift_start = 1'b1;
             end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- counters, byte store, SS ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_reg       <= 1'b1;
      poll_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      byte_idx_reg <= '0;
      for (int i = 0; i < NUM_BYTES; i++) byte_reg[i] <= '0;
    end else begin
      // Registered from the next state so SS lines up with the state it belongs to.
      ss_reg <= !(state_next inside {SETUP, SHIFT, GAP});

      // Poll timer only runs while idle; leaving IDLE (or DONE) clears it.
      poll_cnt_reg <= (state_reg == IDLE && state_next == IDLE) ?
                      poll_cnt_reg + POLL_W'(1) : '0;

      // Shared by SETUP and GAP; restarts on every state change.
      wait_cnt_reg <= ((state_reg == SETUP || state_reg == GAP) && state_next == state_reg) ?
                      wait_cnt_reg + WAIT_W'(1) : '0;

      if (state_reg == IDLE)
        byte_idx_reg <= '0;
      else if (state_reg == GAP && state_next == SHIFT)
        byte_idx_reg <= byte_idx_reg + 3'd1;

      if (state_reg == SHIFT && shift_done) begin
        for (int i = 0; i < NUM_BYTES; i++)
          if (byte_idx_reg == 3'(i)) byte_reg[i] <= shift_rx;
      end
    end
  end

  // ---------------- decode ----------------
  assign axis_sample[AXIS_X] = {byte_reg[1][1:0], byte_reg[0]};
  assign axis_sample[AXIS_Y] = {byte_reg[3][1:0], byte_reg[2]};

  // High bits of the axis-high bytes and spare button bits carry nothing we use.
  assign unused_high_bits = ^{byte_reg[1][7:2], byte_reg[3][7:2], byte_reg[BTN_BYTE][7:2]};

  always_ff @(posedge clk) begin
    if (rst) begin
      x_pos_reg        <= AXIS_CENTER;
      y_pos_reg        <= AXIS_CENTER;
      click_reg        <= 1'b0;
      down_click_reg   <= 1'b0;
      sample_valid_reg <= 1'b0;
    end else begin
      sample_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        x_pos_reg      <= axis_sample[AXIS_X];
        y_pos_reg      <= axis_sample[AXIS_Y];
        click_reg      <= byte_reg[BTN_BYTE][BTN_CLICK_BIT];
        down_click_reg <= byte_reg[BTN_BYTE][BTN_DOWN_CLICK_BIT];
      end
    end
  end

  // ---------------- per-axis step / auto-repeat ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      dir_t             dir_now;
      dir_t             prev_dir_reg;
      logic [REP_W-1:0] rep_cnt_reg;
      logic             neg_pulse_reg, pos_pulse_reg;

      assign dir_now = classify_axis(axis_sample[gi], LOW_TH, HIGH_TH);

      always_ff @(posedge clk) begin
        if (rst) begin
          prev_dir_reg  <= DIR_NONE;
          rep_cnt_reg   <= '0;
          neg_pulse_reg <= 1'b0;
          pos_pulse_reg <= 1'b0;
        end else begin
          neg_pulse_reg <= 1'b0;
          pos_pulse_reg <= 1'b0;
          if (state_reg == DONE) begin
            prev_dir_reg <= dir_now;
            if (dir_now == DIR_NONE) begin
              rep_cnt_reg <= '0;
            end else if (dir_now != prev_dir_reg || rep_cnt_reg == REP_LAST) begin
              // New direction, or held long enough for the next repeat step.
              rep_cnt_reg   <= '0;
              neg_pulse_reg <= (dir_now == DIR_NEG);
              pos_pulse_reg <= (dir_now == DIR_POS);
            end else begin
              rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
            end
          end
        end
      end

      assign axis_neg[gi] = neg_pulse_reg;
      assign axis_pos[gi] = pos_pulse_reg;
    end
  endgenerate

  // ---------------- outputs ----------------
  assign spi.SS       = ss_reg;
  assign spi.MOSI     = 1'b0;
  assign left         = axis_neg[AXIS_X];
  assign right        = axis_pos[AXIS_X];
  assign down         = axis_neg[AXIS_Y];
  assign up           = axis_pos[AXIS_Y];
  assign click        = click_reg;
  assign down_click   = down_click_reg;
  assign x_pos        = x_pos_reg;
  assign y_pos        = y_pos_reg;
  assign sample_valid = sample_valid_reg;

endmodule

// File: tb/tb_pmod_jstk_reader.sv
// Bench for pmod_jstk_reader: joystick slave model on the SPI pins, directed
// protocol/threshold/repeat/button/reset cases, then randomized polls, all
// checked against a behavioural model of the cursor rules.
module tb_pmod_jstk_reader;

  localparam int SCLK_HALF    = 2;
  localparam int SS_SETUP     = 6;
  localparam int BYTE_GAP     = 4;
  localparam int POLL_PERIOD  = 40;
  localparam int LOW_TH       = 256;
  localparam int HIGH_TH      = 768;
  localparam int REPEAT_POLLS = 20;
  localparam int POLL_TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       left, right, up, down, click, down_click, sample_valid;
  logic [9:0] x_pos, y_pos;

  pmod_jstk_reader_if jif ();

  pmod_jstk_reader #(
    .SCLK_HALF    (SCLK_HALF),
    .SS_SETUP     (SS_SETUP),
    .BYTE_GAP     (BYTE_GAP),
    .POLL_PERIOD  (POLL_PERIOD),
    .LOW_TH       (10'(LOW_TH)),
    .HIGH_TH      (10'(HIGH_TH)),
    .REPEAT_POLLS (REPEAT_POLLS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (jif),
    .left         (left),
    .right        (right),
    .up           (up),
    .down         (down),
    .click        (click),
    .down_click   (down_click),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .sample_valid (sample_valid)
  );

  always #5 clk = ~clk;

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- joystick slave + pin monitor ----------------
  logic [39:0] frame = '0;      // b0..b4, b0 in the top byte
  int bitpos = 0, rise_cnt = 0, setup_cnt = 0, last_setup = 0;
  bit in_txn = 0, rise_seen = 0, sclk_prev = 0;

  always @(negedge clk) begin
    if (jif.SS !== 1'b0) begin
      in_txn = 0;
      bitpos = 0;
    end else begin
      if (!in_txn) begin
        in_txn = 1; rise_cnt = 0; setup_cnt = 0; rise_seen = 0; bitpos = 0;
      end
      if (jif.SCLK && !sclk_prev) begin
        rise_cnt++;
        if (!rise_seen) begin rise_seen = 1; last_setup = setup_cnt; end
      end
      if (!rise_seen) setup_cnt++;
      if (!jif.SCLK && sclk_prev) bitpos++;
    end
    sclk_prev = jif.SCLK;
    jif.MISO = (bitpos < 40) ? frame[39 - bitpos] : 1'b0;
  end

  // ---------------- behavioural model ----------------
  int m_prev [2];   // -1 neg, 0 none, +1 pos
  int m_run  [2];   // consecutive polls in the current non-none direction
  bit m_neg  [2];
  bit m_pos  [2];
  int exp_x, exp_y, exp_click, exp_dclick;
  int poll_num = 0;
  bit last_left, last_right, last_up, last_down;

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin m_prev[a] = 0; m_run[a] = 0; end
    exp_x = 512; exp_y = 512; exp_click = 0; exp_dclick = 0;
  endtask

  // A held direction steps on its 1st poll and every REPEAT_POLLS polls after.
  task automatic model_axis(input int ax, input int v);
    int d;
    d = (v <= LOW_TH) ? -1 : ((v >= HIGH_TH) ? 1 : 0);
    if (d == 0)               m_run[ax] = 0;
    else if (d == m_prev[ax]) m_run[ax] = m_run[ax] + 1;
    else                      m_run[ax] = 1;
    m_prev[ax] = d;
    m_neg[ax] = (d == -1) && ((m_run[ax] - 1) % REPEAT_POLLS == 0);
    m_pos[ax] = (d ==  1) && ((m_run[ax] - 1) % REPEAT_POLLS == 0);
  endtask

  task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4);
    frame = {b0, b1, b2, b3, b4};
  endtask

  // Waits for the transaction carrying the current frame and checks its results.
  task automatic run_poll();
    int cyc, b0, b1, b2, b3, b4, ex, ey;
    bit seen, hold_done;
    b0 = int'(frame[39:32]); b1 = int'(frame[31:24]); b2 = int'(frame[23:16]);
    b3 = int'(frame[15:8]);  b4 = int'(frame[7:0]);
    ex = (b1 % 4) * 256 + b0;
    ey = (b3 % 4) * 256 + b2;
    cyc = 0; seen = 0; hold_done = 0;
    while (!seen && cyc < POLL_TIMEOUT) begin
      @(negedge clk);
      cyc++;
      if (sample_valid) seen = 1;
      else begin
        if ({left, right, up, down} != 4'b0)
          check_eq("stray_pulse", 32'({left, right, up, down}), 0);
        if (jif.SS == 1'b0 && !hold_done) begin
          hold_done = 1;
          check_eq("hold_x", 32'(x_pos), exp_x);
          check_eq("hold_y", 32'(y_pos), exp_y);
          check_eq("hold_btn", 32'({click, down_click}), exp_click * 2 + exp_dclick);
          check_eq("mosi", 32'(jif.MOSI), 0);
        end
      end
    end
    if (!seen) begin
      check_eq("sample_timeout", 0, 1);
      return;
    end
    exp_x = ex; exp_y = ey;
    exp_click = (b4 / 2) % 2; exp_dclick = b4 % 2;
    model_axis(0, ex);
    model_axis(1, ey);
    poll_num++;
    check_eq("x_pos", 32'(x_pos), exp_x);
    check_eq("y_pos", 32'(y_pos), exp_y);
    check_eq("click", 32'(click), exp_click);
    check_eq("down_click", 32'(down_click), exp_dclick);
    check_eq("left", 32'(left), 32'(m_neg[0]));
    check_eq("right", 32'(right), 32'(m_pos[0]));
    check_eq("down", 32'(down), 32'(m_neg[1]));
    check_eq("up", 32'(up), 32'(m_pos[1]));
    check_eq("sclk_rises", rise_cnt, 40);
    check_eq("ss_setup_ok", 32'(last_setup >= SS_SETUP), 1);
    last_left = left; last_right = right; last_up = up; last_down = down;
    $display("poll %0d: x=%0d y=%0d click=%0b dclick=%0b L=%0b R=%0b U=%0b D=%0b",
             poll_num, x_pos, y_pos, click, down_click, left, right, up, down);
    @(negedge clk);
    check_eq("pulse_width", 32'({sample_valid, left, right, up, down}), 0);
  endtask

  task automatic poll_xy(input int x, input int y, input logic [7:0] b4);
    logic [7:0] j1, j3;
    j1 = 8'($urandom_range(0, 63));
    j3 = 8'($urandom_range(0, 63));
    set_frame(8'(x % 256), {j1[5:0], 2'(x / 256)}, 8'(y % 256), {j3[5:0], 2'(y / 256)}, b4);
    run_poll();
  endtask

  // Counts clocks from reset release until SS drops.
  task automatic count_to_ss(input string tag);
    int n;
    n = 0;
    while (jif.SS !== 1'b0 && n < 4 * POLL_PERIOD) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq(tag, n, POLL_PERIOD);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ss"}, 32'(jif.SS), 1);
    check_eq({tag, "_sclk"}, 32'(jif.SCLK), 0);
    check_eq({tag, "_x"}, 32'(x_pos), 512);
    check_eq({tag, "_y"}, 32'(y_pos), 512);
    check_eq({tag, "_outs"}, 32'({left, right, up, down, click, down_click, sample_valid}), 0);
  endtask

  function automatic int pick_axis(input int prev);
    int r;
    int edges [6] = '{255, 256, 257, 767, 768, 769};
    r = $urandom_range(0, 5);
    case (r)
      0, 5:    return prev;
      1:       return edges[$urandom_range(0, 5)];
      2:       return $urandom_range(0, 1023);
      3:       return 0;
      default: return 1023;
    endcase
  endfunction

  int down_hits [$];
  int rx, ry, cyc;

  initial begin
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    check_eq("por_mosi", 32'(jif.MOSI), 0);

    // Protocol frame 00,02,FF,03,00: x=512, y=1023.
    set_frame(8'h00, 8'h02, 8'hFF, 8'h03, 8'h00);
    rst = 1'b0;
    count_to_ss("por_poll_period");
    run_poll();
    check_eq("proto_up", 32'(last_up), 1);
    check_eq("proto_lr", 32'({last_left, last_right}), 0);

    // Reset in the middle of a byte.
    set_frame(8'hAA, 8'h55, 8'h33, 8'hCC, 8'h03);
    cyc = 0;
    while (jif.SCLK !== 1'b1 && cyc < POLL_TIMEOUT) begin @(negedge clk); cyc++; end
    check_eq("reach_shift", 32'(jif.SCLK), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    set_frame(8'h00, 8'h02, 8'h00, 8'h02, 8'h00);
    rst = 1'b0;
    count_to_ss("rst_poll_period");
    run_poll();

    // Thresholds.
    poll_xy(256, 512, 8'h00); check_eq("thr_256_left", 32'(last_left), 1);
    poll_xy(257, 512, 8'h00); check_eq("thr_257_none", 32'({last_left, last_right}), 0);
    poll_xy(768, 512, 8'h00); check_eq("thr_768_right", 32'(last_right), 1);
    poll_xy(767, 512, 8'h00); check_eq("thr_767_none", 32'({last_left, last_right}), 0);

    // Auto-repeat: y held at 0 for 45 polls.
    for (int i = 1; i <= 45; i++) begin
      poll_xy(512, 0, 8'h00);
      if (last_down) down_hits.push_back(i);
    end
    check_eq("repeat_count", down_hits.size(), 3);
    if (down_hits.size() == 3) begin
      check_eq("repeat_poll_a", down_hits[0], 1);
      check_eq("repeat_poll_b", down_hits[1], 21);
      check_eq("repeat_poll_c", down_hits[2], 41);
    end

    // Reversal, then diagonal.
    poll_xy(0, 512, 8'h00);    check_eq("rev_left", 32'(last_left), 1);
    poll_xy(1023, 512, 8'h00); check_eq("rev_right", 32'(last_right), 1);
    poll_xy(0, 1023, 8'h00);
    check_eq("diag_left_up", 32'({last_left, last_up}), 2'b11);

    // Buttons.
    poll_xy(512, 512, 8'h03);
    check_eq("btn_03", 32'({click, down_click}), 2'b11);
    poll_xy(512, 512, 8'h04);
    check_eq("btn_04", 32'({click, down_click}), 2'b00);

    // Randomized polls.
    rx = 512; ry = 512;
    for (int i = 0; i < 50; i++) begin
      rx = pick_axis(rx);
      ry = pick_axis(ry);
      poll_xy(rx, ry, 8'($urandom_range(0, 255)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
